// File: rtl/test_task_pkg.sv
// Shared constants and stage-width helpers for the test_task pipeline.
package test_task_pkg;

    // Pipeline depth from the accepting edge to the result edge
    localparam int LAT = 4;

    // Division-by-two modes
    localparam logic DIV_TRUNC = 1'b0;
    localparam logic DIV_FLOOR = 1'b1;

    // Exact stage widths as a function of the operand width
    function automatic int dif_w(input int w);
        return w + 1;
    endfunction

    function automatic int k_w(input int w);
        return w + 3;
    endfunction

    function automatic int d4_w(input int w);
        return w + 2;
    endfunction

    function automatic int p_w(input int w);
        return 2 * w + 4;
    endfunction

    function automatic int r_w(input int w);
        return 2 * w + 5;
    endfunction

    function automatic int q_w(input int w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/test_task_round_sat.sv
// Final stage arithmetic: halve r with the selected rounding, then saturate or wrap.
module test_task_round_sat
    import test_task_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic signed [r_w(WIDTH)-1:0] r_i,
    input  logic                         div_mode_i,
    output logic signed [2*WIDTH-1:0]    y_o,
    output logic                         ovf_o
);

    localparam int R_W = r_w(WIDTH);
    localparam int Q_W = q_w(WIDTH);
    localparam int Y_W = 2 * WIDTH;

    // Floor is a plain arithmetic shift; truncation biases negative values up by one first
    function automatic logic signed [Q_W-1:0] halve(input logic signed [R_W-1:0] r,
                                                    input logic mode);
        logic signed [R_W-1:0] t;
        t = r;
        if (mode != DIV_FLOOR && r[R_W-1]) begin
            t = r + R_W'(1);
        end
        return Q_W'(t >>> 1);
    endfunction

    // q fits the result range only when all bits above the result sign bit match it
    function automatic logic out_of_range(input logic signed [Q_W-1:0] q);
        logic [Q_W-Y_W:0] upper;
        upper = q[Q_W-1:Y_W-1];
        return !((&upper) | ~(|upper));
    endfunction

    function automatic logic signed [Y_W-1:0] clamp(input logic signed [Q_W-1:0] q);
        if (!out_of_range(q)) begin
            return Y_W'(q);
        end else if (q[Q_W-1]) begin
            return {1'b1, {(Y_W-1){1'b0}}};
        end else begin
            return {1'b0, {(Y_W-1){1'b1}}};
        end
    endfunction

    logic signed [Q_W-1:0] q;

    // Halve, flag overflow, then clamp or truncate to the result width
    always_comb begin
        q     = halve(r_i, div_mode_i);
        ovf_o = out_of_range(q);
        if (SAT) begin
            y_o = clamp(q);
        end else begin
            y_o = Y_W'(q);
        end
    end

endmodule

// File: rtl/test_task_pipe.sv
// Pipelined valid/ready evaluator of y = ((a-b)*(1+3*c) - 4*d) / 2.
module test_task_pipe
    import test_task_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [WIDTH-1:0]   c,
    input  logic signed [WIDTH-1:0]   d,
    input  logic                      div_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] y,
    output logic                      ovf
);

    localparam int DIF_W = dif_w(WIDTH);
    localparam int K_W   = k_w(WIDTH);
    localparam int D4_W  = d4_w(WIDTH);
    localparam int P_W   = p_w(WIDTH);
    localparam int R_W   = r_w(WIDTH);

    // Whole pipe advances together; it only stops when a result is waiting unread
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // vld_pipe_q[0] is the operand register, [1..3] are S1..S3, [LAT] is the result
    logic [LAT:0] vld_pipe_q;

    logic signed [WIDTH-1:0] a_p0_q, b_p0_q, c_p0_q, d_p0_q;
    logic                    mode_p0_q;

    logic signed [DIF_W-1:0] dif_p1_d, dif_p1_q;
    logic signed [K_W-1:0]   k_p1_d, k_p1_q;
    logic signed [D4_W-1:0]  d4_p1_d, d4_p1_q;
    logic                    mode_p1_q;

    logic signed [P_W-1:0]   p_p2_d, p_p2_q;
    logic signed [D4_W-1:0]  d4_p2_q;
    logic                    mode_p2_q;

    logic signed [R_W-1:0]   r_p3_d, r_p3_q;
    logic                    mode_p3_q;

    logic signed [2*WIDTH-1:0] y_p4_d, y_p4_q;
    logic                      ovf_p4_d, ovf_p4_q;

    // Valid bits shift with the data; a bubble enters as a zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe_q <= '0;
        end else if (en) begin
            vld_pipe_q <= {vld_pipe_q[LAT-1:0], in_valid};
        end
    end

    // ---- operand capture ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_p0_q    <= '0;
            b_p0_q    <= '0;
            c_p0_q    <= '0;
            d_p0_q    <= '0;
            mode_p0_q <= 1'b0;
        end else if (en) begin
            a_p0_q    <= a;
            b_p0_q    <= b;
            c_p0_q    <= c;
            d_p0_q    <= d;
            mode_p0_q <= div_mode;
        end
    end

    // ---- S1: difference, 1+3c and 4d at exact widths ----
    always_comb begin
        dif_p1_d = DIF_W'(a_p0_q) - DIF_W'(b_p0_q);
        k_p1_d   = K_W'(1) + K_W'(c_p0_q) + (K_W'(c_p0_q) <<< 1);
        d4_p1_d  = D4_W'(d_p0_q) <<< 2;
    end

    // S1 register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dif_p1_q  <= '0;
            k_p1_q    <= '0;
            d4_p1_q   <= '0;
            mode_p1_q <= 1'b0;
        end else if (en) begin
            dif_p1_q  <= dif_p1_d;
            k_p1_q    <= k_p1_d;
            d4_p1_q   <= d4_p1_d;
            mode_p1_q <= mode_p0_q;
        end
    end

    // ---- S2: full-width signed product ----
    assign p_p2_d = P_W'(dif_p1_q) * P_W'(k_p1_q);

    // S2 register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_p2_q    <= '0;
            d4_p2_q   <= '0;
            mode_p2_q <= 1'b0;
        end else if (en) begin
            p_p2_q    <= p_p2_d;
            d4_p2_q   <= d4_p1_q;
            mode_p2_q <= mode_p1_q;
        end
    end

    // ---- S3: subtract 4d with one guard bit ----
    assign r_p3_d = R_W'(p_p2_q) - R_W'(d4_p2_q);

    // S3 register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p3_q    <= '0;
            mode_p3_q <= 1'b0;
        end else if (en) begin
            r_p3_q    <= r_p3_d;
            mode_p3_q <= mode_p2_q;
        end
    end

    // ---- S4: halve, overflow detect, saturate or wrap ----
    test_task_round_sat #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_round_sat (
        .r_i        (r_p3_q),
        .div_mode_i (mode_p3_q),
        .y_o        (y_p4_d),
        .ovf_o      (ovf_p4_d)
    );

    // Result register, held while the sink stalls
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_p4_q   <= '0;
            ovf_p4_q <= 1'b0;
        end else if (en) begin
            y_p4_q   <= y_p4_d;
            ovf_p4_q <= ovf_p4_d;
        end
    end

    assign out_valid = vld_pipe_q[LAT];
    assign y         = y_p4_q;
    assign ovf       = ovf_p4_q;

endmodule

// File: doc/test_task_pipe.md
Name: test_task_pipe

Overview:
- Pipelined, handshaked successor of the combinational `test_task` evaluator.
- Computes y = ((a-b)*(1+3*c) - 4*d) / 2 on signed operands.
- Generalised over operand width; adds a selectable rounding mode, optional saturation and an overflow flag.
- Sits between a valid/ready operand source and a valid/ready result sink; one result per cycle when unstalled.

Parameters:
- WIDTH, 8: signed operand width a/b/c/d; result is 2*WIDTH.
- SAT, 1: 1 = saturate the result to the 2*WIDTH signed range; 0 = wrap (two's-complement truncation).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand.
- c  in  WIDTH  signed operand.
- d  in  WIDTH  signed operand.
- div_mode  in  1  0 = /2 truncates toward zero; 1 = /2 floors (arithmetic shift). Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- y  out  2*WIDTH  signed result.
- ovf  out  1  the exact result did not fit in 2*WIDTH signed; qualified by out_valid.

Behaviour:
- Reset (RST_N=0, async): all stage valid bits, out_valid, y and ovf go to 0. The pipeline data registers also clear to 0.
- Reset mid-operation: in-flight beats are discarded, none are emitted, and the block accepts new beats on the first edge after release.
- Stall: global enable en = out_ready | ~out_valid. When en=0 all stages hold, including valid bits, data and div_mode. in_ready = en, combinationally.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - A bubble (in_valid=0 while en=1) advances as an invalid stage.
- Latency: exactly 4 enabled cycles. A beat accepted at edge N is visible on y/out_valid after edge N+4 if never stalled. Throughput is 1 beat/cycle.
- Stage S1:
  - dif = a - b, computed at WIDTH+1 bits.
  - k = 1 + c + (c<<<1), computed at WIDTH+3 bits.
  - d4 = d<<<2, computed at WIDTH+2 bits.
  - div_mode is registered alongside.
- Stage S2: p = dif*k at 2*WIDTH+4 bits; d4 and div_mode are delayed.
- Stage S3: r = p - d4, sign-extended to 2*WIDTH+5 bits.
- Stage S4, division by 2:
  - div_mode=1: q = r>>>1.
  - div_mode=0: q = (r + (r<0 ? 1 : 0))>>>1.
  - q is 2*WIDTH+4 bits.
- Stage S4, overflow and output:
  - ovf = q outside [-2^(2W-1), 2^(2W-1)-1].
  - SAT=1 clamps y to the nearest bound.
  - SAT=0 takes the low 2*WIDTH bits.
  - ovf is reported in both modes.
- Ordering:
  - Results leave in acceptance order.
  - No beat is dropped or duplicated under any in_valid/out_ready pattern.
  - y, ovf and out_valid are stable while out_valid=1 and out_ready=0.
- All internal widths are exact. No intermediate truncation is allowed before S4.

Decomposition:
- Package test_task_pkg:
  - localparams for stage widths as functions of WIDTH: DIF_W=W+1, K_W=W+3, P_W=2W+4, R_W=2W+5.
  - Constants DIV_TRUNC=1'b0 and DIV_FLOOR=1'b1.
  - Pipeline depth constant LAT=4.
- One sub-module, test_task_round_sat. It is combinational: (r, div_mode) -> (y, ovf) with the SAT parameter. It is instantiated in S4 and unit-testable on its own.

Test Plan:
- Reset then a=b=c=d=1, mode 0, out_ready=1 -> y=-2, ovf=0 exactly 4 cycles after acceptance.
- a=4,b=3,c=3,d=1 -> y=3. Then a=127,b=c=d=0 -> y=63. Sent back-to-back, the results arrive on consecutive cycles in order.
- a=0,b=1,c=0,d=0 (r=-1):
  - mode 0 -> y=0.
  - mode 1 -> y=-1.
  - Modes alternate per beat and each result must use its own mode.
- WIDTH=8, a=127,b=-128,c=-128,d=127 (r=-98173):
  - mode 0, SAT=1 -> y=-32768, ovf=1.
  - SAT=0 -> y=16450, ovf=1.
- Backpressure:
  - Stream 10 random beats and toggle out_ready pseudo-randomly.
  - in_ready must fall whenever out_valid=1 and out_ready=0.
  - Output must match the reference model sequence exactly, with y held stable while stalled.
- Assert RST_N=0 with 3 beats in flight -> out_valid=0 immediately. After release, no stale result appears and a new beat returns after 4 cycles.
